// File: rtl/load_store_unit.sv
// RV32I load/store unit: runs one data-memory transaction per request over a
// valid/ready handshake, aligning stores into byte lanes and extending loads.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  state_t state, state_next;

  logic             write_q;
  logic [2:0]       f3_q;
  logic [1:0]       lo_q;
  logic             fault_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             timeout_hit;

  logic             illegal_f3;
  logic             misaligned;
  logic             req_fault;
  logic [1:0]       req_cause;
  logic [31:0]      req_wdata;
  logic [3:0]       req_wstrb;

  logic [31:0]      rdata_shifted;
  logic [31:0]      load_extracted;

  // Request decode; the U bit has no meaning for stores, so SBU/SHU are illegal.
  always_comb begin
    illegal_f3 = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                 (req_write && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    req_fault  = illegal_f3 || misaligned;

    if (illegal_f3) begin
      req_cause = CAUSE_ILLEGAL;
    end else if (misaligned) begin
      req_cause = CAUSE_MISALIGN;
    end else begin
      req_cause = CAUSE_NONE;
    end

    req_wdata = '0;
    req_wstrb = '0;
    if (req_write && !req_fault) begin
      case (funct3[1:0])
        2'b00: begin
          req_wdata = {4{store_data[7:0]}};
          req_wstrb = 4'b0001 << addr[1:0];
        end
        2'b01: begin
          req_wdata = {2{store_data[15:0]}};
          req_wstrb = 4'b0011 << addr[1:0];
        end
        default: begin
          req_wdata = store_data;
          req_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    rdata_shifted = mem_rdata >> {lo_q, 3'b000};
    case (f3_q)
      3'b000:  load_extracted = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_extracted = {24'h0, rdata_shifted[7:0]};
      3'b001:  load_extracted = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_extracted = {16'h0, rdata_shifted[15:0]};
      default: load_extracted = mem_rdata;
    endcase
  end

  assign timeout_hit = TIMEOUT_EN && (tmo_cnt == CNT_LAST) && !mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          state_next = req_fault ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ready || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fault = done && fault_q;

  // Request capture, handshake completion and the wait-state counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_q     <= 1'b0;
      f3_q        <= 3'b000;
      lo_q        <= 2'b00;
      fault_q     <= 1'b0;
      fault_cause <= CAUSE_NONE;
      load_data   <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            f3_q      <= funct3;
            lo_q      <= addr[1:0];
            mem_we    <= req_write && !req_fault;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= req_wdata;
            mem_wstrb <= req_wstrb;
            tmo_cnt   <= '0;
            if (req_fault) begin
              fault_q     <= 1'b1;
              fault_cause <= req_cause;
            end
          end
        end
        ACCESS: begin
          if (mem_ready) begin
            fault_q     <= 1'b0;
            fault_cause <= CAUSE_NONE;
            if (!write_q) begin
              load_data <= load_extracted;
            end
          end else if (timeout_hit) begin
            fault_q     <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised scoreboard bench for load_store_unit: the driver acts as core and
// memory and queues predicted responses; a negedge monitor checks what appears.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] ld;
    logic        issued;
    int          mem_cycles;
    int          stall_cycles;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } memx_t;

  resp_t       resp_q[$];
  memx_t       mem_q[$];
  int          checks;
  int          failures;
  logic [31:0] last_load;
  int          stall_cnt;
  int          mem_cnt;
  resp_t       mon_r;
  memx_t       mon_m;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault),
    .fault_cause(fault_cause),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst       = 1'b0;
    req_valid = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    last_load = '0;
  endtask

  // Issues one request from a clean IDLE cycle, predicts its outcome from the
  // ISA rules, then plays the memory side with w wait states.
  task automatic applyStimulus(input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] sd,
                               input int w, input logic [31:0] rd);
    int          idx;
    int          size;
    logic        legal;
    logic        misal;
    resp_t       r;
    memx_t       m;
    logic [31:0] sh;
    longint      v;
    longint      span;
    int          acc;
    int          lat;
    bit          finished;

    idx   = int'(a % 32'd4);
    legal = (f3 <= 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
    size  = legal ? (1 << (f3 % 3'd4)) : 1;
    misal = legal && ((a % 32'(size)) != 0);

    r.ld           = last_load;
    r.issued       = 1'b0;
    r.mem_cycles   = 0;
    r.stall_cycles = 1;
    r.fault        = 1'b1;
    r.cause        = 2'd0;
    if (!legal) begin
      r.cause = 2'd3;
    end else if (misal) begin
      r.cause = 2'd1;
    end else begin
      r.issued = 1'b1;
      m.we     = wr;
      m.addr   = a - 32'(idx);
      m.wstrb  = '0;
      m.wdata  = '0;
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (i >= idx && i < idx + size) m.wstrb[i] = 1'b1;
          m.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
        end
      end
      mem_q.push_back(m);
      if (w >= TO) begin
        r.cause        = 2'd2;
        r.mem_cycles   = TO;
        r.stall_cycles = TO + 1;
      end else begin
        r.fault        = 1'b0;
        r.mem_cycles   = w + 1;
        r.stall_cycles = w + 2;
        if (!wr) begin
          sh   = rd >> (8 * idx);
          span = longint'(1) << (8 * size);
          v    = longint'(sh) % span;
          if (f3 < 3'd4 && size < 4 && v >= span / 2) v = v - span;
          r.ld = v[31:0];
        end
      end
    end
    last_load = r.ld;
    resp_q.push_back(r);

    req_valid  = 1'b1;
    req_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    mem_ready  = 1'b0;
    acc        = 0;
    lat        = 0;
    finished   = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(posedge clk);
      #1;
      req_valid  = 1'($urandom_range(0, 1));
      req_write  = 1'($urandom);
      funct3     = 3'($urandom);
      addr       = $urandom;
      store_data = $urandom;
      if (done) begin
        mem_ready = 1'b0;
        finished  = 1'b1;
        lat       = c + 1;
      end else if (mem_req) begin
        mem_ready = (acc == w);
        mem_rdata = (acc == w) ? rd : $urandom;
        acc++;
      end else begin
        mem_ready = 1'b0;
      end
    end
    if (!finished) begin
      checkOutput("done_within_bound", 32'(done), 32'd1);
      doReset();
    end else begin
      checkOutput("done_latency", 32'(lat), 32'(r.stall_cycles));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      mem_ready = 1'b0;
    end
  endtask

  // Monitor: memory-side fields while mem_req is up, response on done.
  always @(negedge clk) begin
    if (!rst) begin
      resp_q.delete();
      mem_q.delete();
      stall_cnt = 0;
      mem_cnt   = 0;
    end else begin
      if (stall) stall_cnt++;
      if (mem_req) begin
        mem_cnt++;
        if (mem_q.size() == 0) begin
          checkOutput("unexpected_mem_req", 32'(mem_req), 32'd0);
        end else begin
          mon_m = mem_q[0];
          checkOutput("mem_we", 32'(mem_we), 32'(mon_m.we));
          checkOutput("mem_addr", mem_addr, mon_m.addr);
          checkOutput("mem_wstrb", 32'(mem_wstrb), 32'(mon_m.wstrb));
          if (mon_m.we) checkOutput("mem_wdata", mem_wdata, mon_m.wdata);
        end
      end
      if (done) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          mon_r = resp_q.pop_front();
          checkOutput("fault", 32'(fault), 32'(mon_r.fault));
          if (mon_r.fault) checkOutput("fault_cause", 32'(fault_cause), 32'(mon_r.cause));
          checkOutput("load_data", load_data, mon_r.ld);
          checkOutput("stall_cycles", 32'(stall_cnt), 32'(mon_r.stall_cycles));
          checkOutput("mem_req_cycles", 32'(mem_cnt), 32'(mon_r.mem_cycles));
          checkOutput("stall_in_resp", 32'(stall), 32'd0);
          if (mon_r.issued && mem_q.size() != 0) void'(mem_q.pop_front());
        end
        stall_cnt = 0;
        mem_cnt   = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    last_load  = '0;
    stall_cnt  = 0;
    mem_cnt    = 0;
    rst        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    funct3     = 3'b000;
    addr       = '0;
    store_data = '0;
    mem_ready  = 1'b0;
    mem_rdata  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_fault", 32'(fault), 32'd0);
    checkOutput("reset_fault_cause", 32'(fault_cause), 32'd0);
    checkOutput("reset_load_data", load_data, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset_mem_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);

    $display("[TB] directed cases");
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
    applyStimulus(1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
    applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 32'h8011_2233);
    applyStimulus(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'h0);
    applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0, 0, 32'h0);
    applyStimulus(1'b1, 3'b100, 32'h0000_0100, 32'h55, 0, 32'h0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0, 100, 32'h0);

    $display("[TB] reset during access");
    mem_q.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, wstrb: 4'h0});
    resp_q.push_back('{fault: 1'b0, cause: 2'd0, ld: 32'h0, issued: 1'b1,
                       mem_cycles: 1, stall_cycles: 2});
    req_valid = 1'b1;
    req_write = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_0400;
    mem_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    checkOutput("rst_test_mem_req_c1", 32'(mem_req), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    last_load = '0;
    checkOutput("rst_test_mem_req_after", 32'(mem_req), 32'd0);
    checkOutput("rst_test_done_after", 32'(done), 32'd0);
    checkOutput("rst_test_stall_low", 32'(stall), 32'd0);
    checkOutput("rst_test_load_data", load_data, 32'd0);
    req_valid = 1'b1;
    funct3    = 3'b010;
    addr      = 32'h0000_0104;
    #1 checkOutput("rst_test_stall_follows", 32'(stall), 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h0000_0104, 32'h0, 1, 32'h600D_F00D);

    $display("[TB] random cases");
    for (int n = 0; n < 300; n++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      wr = 1'($urandom);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(wr, f3, a, $urandom, $urandom_range(0, 5), $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
